// File: rtl/serial_deserializer.sv
`default_nettype none
// ============================================================================
// Module      : serial_deserializer
// Description : Builds WIDTH-bit words from serial bits, taking one bit on
//               each rising edge of write_in. The word is held behind a
//               data_ready/ack_in handshake. WIDTH must be at least 2.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_deserializer #(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             clock_1MHz,
    input  logic             rst,
    input  logic             data_in,
    input  logic             write_in,
    input  logic             ack_in,
    output logic             status_out,
    output logic             data_ready,
    output logic [WIDTH-1:0] data_out
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(WIDTH - 1);

    localparam logic [1:0] S_INIT    = 2'd0;
    localparam logic [1:0] S_COLLECT = 2'd1;
    localparam logic [1:0] S_HOLD    = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_next_state;
    logic             r_write_q;
    logic             w_wr_edge;
    logic             w_accept;
    logic             w_last_bit;
    logic [CNT_W-1:0] r_count;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] w_shift_next;

    assign w_wr_edge  = write_in & ~r_write_q;
    assign w_accept   = (r_state == S_COLLECT) && w_wr_edge;
    assign w_last_bit = w_accept && (r_count == c_LAST);

    // LSB-first shifts toward bit 0 so the first bit ends up in data_out[0].
    generate
        if (LSB_FIRST) begin : g_lsb_first
            assign w_shift_next = {data_in, r_shift[WIDTH-1:1]};
        end else begin : g_msb_first
            assign w_shift_next = {r_shift[WIDTH-2:0], data_in};
        end
    endgenerate

    always_ff @(posedge clock_1MHz) begin
        if (rst) begin
            r_state <= S_INIT;
        end else begin
            r_state <= w_next_state;
        end
    end

    // A final edge in COLLECT always lands in HOLD; ack is only honoured there.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_INIT:    w_next_state = S_COLLECT;
            S_COLLECT: if (w_last_bit) w_next_state = S_HOLD;
            S_HOLD:    if (ack_in) w_next_state = S_COLLECT;
            default:   w_next_state = S_INIT;
        endcase
    end

    always_comb begin
        status_out = (r_state == S_COLLECT);
        data_ready = (r_state == S_HOLD);
    end

    // Edge tracker keeps running in every state; reset value of 1 masks a
    // strobe that is already high when reset releases.
    always_ff @(posedge clock_1MHz) begin
        if (rst) begin
            r_write_q <= 1'b1;
        end else begin
            r_write_q <= write_in;
        end
    end

    always_ff @(posedge clock_1MHz) begin
        if (rst) begin
            r_count  <= '0;
            r_shift  <= '0;
            data_out <= '0;
        end else if (w_last_bit) begin
            r_count  <= '0;
            r_shift  <= '0;
            data_out <= w_shift_next;
        end else if (w_accept) begin
            r_count  <= r_count + 1'b1;
            r_shift  <= w_shift_next;
        end
    end

endmodule
`default_nettype wire
